// File: rtl/controle_det_arbitro.sv
// Round-robin sequencer sharing one determinant core between requesters A and B.
// Optional macro CTRL_DET_SATURACAO_EN: registers saturou when the captured result hits a clamp limit.
module controle_det_arbitro #(
    parameter int unsigned LAT_5X5   = 5,
    parameter int unsigned LAT_MENOR = 1,
    parameter int unsigned TAM_MIN   = 2,
    parameter int unsigned TAM_MAX   = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req_a,
    input  logic         req_b,
    input  logic [199:0] matriz_a,
    input  logic [199:0] matriz_b,
    input  logic [7:0]   tam_a,
    input  logic [7:0]   tam_b,
    output logic         gnt_a,
    output logic         gnt_b,
    output logic         done_a,
    output logic         done_b,
    output logic [7:0]   resultado_out,
    output logic         erro_tam,
    output logic         ocupado,
    output logic         saturou,
    output logic [199:0] core_matriz,
    output logic [7:0]   core_tamanho,
    input  logic [7:0]   core_resultado
);
    localparam int unsigned CW = $clog2(LAT_5X5 + 1);
    localparam logic [7:0] TMIN8 = 8'(TAM_MIN);
    localparam logic [7:0] TMAX8 = 8'(TAM_MAX);

    typedef enum logic [1:0] {OCIOSO, RESSINC, EXECUTA, CAPTURA} estado_t;

    estado_t        r_estado;
    estado_t        w_prox_estado;
    logic           r_ptr_b;
    logic           r_lado_b;
    logic [199:0]   r_matriz;
    logic [7:0]     r_tam;
    logic [CW-1:0]  r_cnt;
    logic           r_erro_pend;
    logic           r_gnt_a, r_gnt_b, r_done_a, r_done_b;
    logic [7:0]     r_resultado;
    logic           r_erro;
    logic           r_ocupado;
    // Mirrors the core's column counter; the core is never reset, so neither is this.
    logic [2:0]     r_fase = 3'd0;

    logic           w_req_any;
    logic           w_conc_a;
    logic           w_concede;
    logic [7:0]     w_tam_sel;
    logic           w_tam_ok;

    assign w_req_any = req_a | req_b;
    assign w_conc_a  = req_a & (~r_ptr_b | ~req_b);
    assign w_tam_sel = w_conc_a ? tam_a : tam_b;
    assign w_tam_ok  = (w_tam_sel >= TMIN8) && (w_tam_sel <= TMAX8);
    assign w_concede = (r_estado == OCIOSO) && (r_fase == 3'd0) && w_req_any;

    always_ff @(posedge clock) begin
        if (reset) r_estado <= OCIOSO;
        else       r_estado <= w_prox_estado;
    end

    always_comb begin
        w_prox_estado = r_estado;
        case (r_estado)
            OCIOSO: begin
                if (r_fase != 3'd0)  w_prox_estado = RESSINC;
                else if (w_req_any)  w_prox_estado = w_tam_ok ? EXECUTA : CAPTURA;
            end
            RESSINC: begin
                if (r_fase == 3'd4 || r_fase == 3'd0) w_prox_estado = OCIOSO;
            end
            EXECUTA: begin
                if (r_cnt == CW'(1)) w_prox_estado = CAPTURA;
            end
            CAPTURA: w_prox_estado = OCIOSO;
            default: w_prox_estado = OCIOSO;
        endcase
    end

    always_comb begin
        core_tamanho = 8'd0;
        core_matriz  = '0;
        case (r_estado)
            EXECUTA: begin
                core_tamanho = r_tam;
                core_matriz  = r_matriz;
            end
            RESSINC: core_tamanho = 8'd5;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (core_tamanho == 8'd5)
            r_fase <= (r_fase == 3'd4) ? 3'd0 : r_fase + 3'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr_b     <= 1'b0;
            r_lado_b    <= 1'b0;
            r_matriz    <= '0;
            r_tam       <= 8'd0;
            r_cnt       <= '0;
            r_erro_pend <= 1'b0;
            r_gnt_a     <= 1'b0;
            r_gnt_b     <= 1'b0;
            r_done_a    <= 1'b0;
            r_done_b    <= 1'b0;
            r_resultado <= 8'd0;
            r_erro      <= 1'b0;
            r_ocupado   <= 1'b0;
        end else begin
            r_gnt_a  <= w_concede & w_conc_a;
            r_gnt_b  <= w_concede & ~w_conc_a;
            r_done_a <= (r_estado == CAPTURA) & ~r_lado_b;
            r_done_b <= (r_estado == CAPTURA) & r_lado_b;
            if (w_concede) begin
                r_matriz    <= w_conc_a ? matriz_a : matriz_b;
                r_tam       <= w_tam_sel;
                r_lado_b    <= ~w_conc_a;
                r_ptr_b     <= w_conc_a;
                r_ocupado   <= 1'b1;
                r_erro_pend <= ~w_tam_ok;
                r_cnt       <= (w_tam_sel == 8'd5) ? CW'(LAT_5X5) : CW'(LAT_MENOR);
            end
            if (r_estado == EXECUTA)
                r_cnt <= r_cnt - 1'b1;
            if (r_estado == CAPTURA) begin
                r_resultado <= r_erro_pend ? 8'd0 : core_resultado;
                r_erro      <= r_erro_pend;
                r_ocupado   <= 1'b0;
            end
        end
    end

`ifdef CTRL_DET_SATURACAO_EN
    logic r_saturou;
    always_ff @(posedge clock) begin
        if (reset)
            r_saturou <= 1'b0;
        else if (r_estado == CAPTURA)
            r_saturou <= ~r_erro_pend & ((core_resultado == 8'h7F) | (core_resultado == 8'h80));
    end
    assign saturou = r_saturou;
`else
    assign saturou = 1'b0;
`endif

    assign gnt_a         = r_gnt_a;
    assign gnt_b         = r_gnt_b;
    assign done_a        = r_done_a;
    assign done_b        = r_done_b;
    assign resultado_out = r_resultado;
    assign erro_tam      = r_erro;
    assign ocupado       = r_ocupado;
endmodule

// File: tb/tb_controle_det_arbitro.sv
// Scoreboard bench for controle_det_arbitro with a triangular-matrix core stand-in.
module tb_controle_det_arbitro;
    logic         clock = 1'b0;
    logic         reset;
    logic         req_a, req_b;
    logic [199:0] matriz_a, matriz_b;
    logic [7:0]   tam_a, tam_b;
    logic         gnt_a, gnt_b, done_a, done_b;
    logic [7:0]   resultado_out;
    logic         erro_tam, ocupado, saturou;
    logic [199:0] core_matriz;
    logic [7:0]   core_tamanho;
    logic [7:0]   core_resultado = 8'd0;

`ifdef CTRL_DET_SATURACAO_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    controle_det_arbitro dut (
        .clock(clock), .reset(reset),
        .req_a(req_a), .req_b(req_b),
        .matriz_a(matriz_a), .matriz_b(matriz_b),
        .tam_a(tam_a), .tam_b(tam_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .done_a(done_a), .done_b(done_b),
        .resultado_out(resultado_out), .erro_tam(erro_tam),
        .ocupado(ocupado), .saturou(saturou),
        .core_matriz(core_matriz), .core_tamanho(core_tamanho),
        .core_resultado(core_resultado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Test matrices are upper triangular, so the core stand-in only needs the diagonal product.
    function automatic logic [7:0] core_det(logic [199:0] m, int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * int'($signed(m[(6*i)*8 +: 8]));
        if (p > 127)  p = 127;
        if (p < -128) p = -128;
        return 8'(p);
    endfunction

    always @(posedge clock)
        if (core_tamanho != 8'd0) core_resultado <= core_det(core_matriz, int'(core_tamanho));

    function automatic logic [199:0] mk(int d0, int d1, int d2, int d3, int d4);
        logic [199:0] m = '0;
        m[0 +: 8]   = 8'(d0);
        m[48 +: 8]  = 8'(d1);
        m[96 +: 8]  = 8'(d2);
        m[144 +: 8] = 8'(d3);
        m[192 +: 8] = 8'(d4);
        m[8 +: 8]   = 8'd7;
        return m;
    endfunction

    typedef struct {
        bit lado_b;
        int res;
        bit erro;
        bit sat;
        int drv;
        int lat;
        int tam;
    } exp_t;

    exp_t done_q[$];
    bit   gnt_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   active = 1'b0;

    task automatic check(string nome, longint act, longint req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nome, act, req, cyc);
        end
    endtask

    task automatic esperar(bit b, int r, bit e, bit s, int drv, int lat, int t);
        exp_t x;
        x.lado_b = b; x.res = r; x.erro = e; x.sat = s; x.drv = drv; x.lat = lat; x.tam = t;
        done_q.push_back(x);
    endtask

    // Monitor: pops expectations whenever the DUT presents gnt or done.
    initial begin
        int   cyc0 = 0;
        int   drv  = 0;
        exp_t x;
        forever begin
            @(negedge clock);
            if (gnt_a || gnt_b) begin
                if (gnt_a && gnt_b) check("gnt_both", 1, 0);
                else if (gnt_q.size() == 0) check("gnt_unexpected", 1, 0);
                else check("gnt_side", gnt_b, gnt_q.pop_front());
                check("ocupado_at_gnt", ocupado, 1);
                active = 1'b1;
                cyc0   = cyc;
                drv    = 0;
            end
            if (active && core_tamanho != 8'd0 && done_q.size() > 0)
                if (int'(core_tamanho) == done_q[0].tam && core_matriz != '0) drv++;
            if (done_a || done_b) begin
                if (done_q.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    x = done_q.pop_front();
                    $display("done side=%0d res=%0d erro=%0d sat=%0d lat=%0d drv=%0d",
                             done_b, $signed(resultado_out), erro_tam, saturou, cyc - cyc0, drv);
                    check("done_side", done_b, x.lado_b);
                    check("done_excl", done_a && done_b, 0);
                    check("resultado", $signed(resultado_out), x.res);
                    check("erro_tam", erro_tam, x.erro);
                    check("saturou", saturou, x.sat);
                    check("core_drive_cycles", drv, x.drv);
                    check("latency", cyc - cyc0, x.lat);
                    check("ocupado_at_done", ocupado, 0);
                end
                active = 1'b0;
            end else if (!ocupado) begin
                active = 1'b0;
            end
        end
    end

    task automatic pedir(bit b, logic [199:0] m, logic [7:0] t);
        bit ok = 1'b0;
        @(negedge clock);
        if (b) begin req_b = 1'b1; matriz_b = m; tam_b = t; end
        else   begin req_a = 1'b1; matriz_a = m; tam_a = t; end
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clock);
            ok = b ? gnt_b : gnt_a;
        end
        if (!ok) check("gnt_timeout", 0, 1);
        if (b) req_b = 1'b0; else req_a = 1'b0;
    endtask

    task automatic drenar();
        int i = 0;
        while ((done_q.size() != 0 || active) && i < 500) begin
            @(negedge clock);
            i++;
        end
        if (i >= 500) check("drain_timeout", done_q.size(), 0);
        repeat (2) @(negedge clock);
    endtask

    logic [199:0] ident5;

    initial begin
        int n_res;
        bit got;
        ident5 = mk(1, 1, 1, 1, 1);
        reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
        matriz_a = '0; matriz_b = '0; tam_a = 8'd0; tam_b = 8'd0;
        repeat (3) @(negedge clock);
        check("rst_gnt", {gnt_a, gnt_b, done_a, done_b}, 0);
        check("rst_flags", {erro_tam, ocupado, saturou}, 0);
        check("rst_resultado", resultado_out, 0);
        check("rst_core_tam", core_tamanho, 0);
        check("rst_core_matriz", core_matriz != '0, 0);
        reset = 1'b0;

        // 5x5 identity via A
        gnt_q.push_back(1'b0); esperar(1'b0, 1, 1'b0, 1'b0, 5, 6, 5);
        pedir(1'b0, ident5, 8'd5);
        drenar();

        // Illegal sizes via B: 7 and 1; core must not be driven
        gnt_q.push_back(1'b1); esperar(1'b1, 0, 1'b1, 1'b0, 0, 1, 7);
        pedir(1'b1, ident5, 8'd7);
        drenar();
        gnt_q.push_back(1'b1); esperar(1'b1, 0, 1'b1, 1'b0, 0, 1, 1);
        pedir(1'b1, ident5, 8'd1);
        drenar();

        // Simultaneous 3x3 requests, pointer at A
        gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
        esperar(1'b0, 2, 1'b0, 1'b0, 1, 2, 3);
        esperar(1'b1, -3, 1'b0, 1'b0, 1, 2, 3);
        fork
            pedir(1'b0, mk(1, 1, 2, 0, 0), 8'd3);
            pedir(1'b1, mk(1, -3, 1, 0, 0), 8'd3);
        join
        drenar();

        // Clamp limits: +1000 -> 127, -1000 -> -128
        gnt_q.push_back(1'b0); esperar(1'b0, 127, 1'b0, SAT_ON, 5, 6, 5);
        pedir(1'b0, mk(10, 10, 10, 1, 1), 8'd5);
        drenar();
        gnt_q.push_back(1'b1); esperar(1'b1, -128, 1'b0, SAT_ON, 5, 6, 5);
        pedir(1'b1, mk(-10, 10, 10, 1, 1), 8'd5);
        drenar();
        gnt_q.push_back(1'b1); esperar(1'b1, 6, 1'b0, 1'b0, 5, 6, 5);
        pedir(1'b1, mk(1, 2, 3, 1, 1), 8'd5);
        drenar();

        // Reset after two EXECUTA cycles, then resync and a fresh 5x5 via B
        gnt_q.push_back(1'b0);
        pedir(1'b0, mk(2, 1, 1, 1, 1), 8'd5);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_mid_ocupado", ocupado, 0);
        check("rst_mid_core_tam", core_tamanho, 0);
        gnt_q.push_back(1'b1); esperar(1'b1, 1, 1'b0, 1'b0, 5, 6, 5);
        req_b = 1'b1; matriz_b = ident5; tam_b = 8'd5;
        n_res = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            got = gnt_b;
            if (!got && core_tamanho == 8'd5 && core_matriz == '0) n_res++;
        end
        req_b = 1'b0;
        check("ressinc_cycles", n_res, 3);
        check("gnt_after_ressinc", got, 1);
        drenar();

        // Continuous requests from both: grants alternate A,B,A,B
        gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
        gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
        esperar(1'b0, 16, 1'b0, 1'b0, 1, 2, 4);
        esperar(1'b1, -15, 1'b0, 1'b0, 1, 2, 2);
        esperar(1'b0, 16, 1'b0, 1'b0, 1, 2, 4);
        esperar(1'b1, -15, 1'b0, 1'b0, 1, 2, 2);
        fork
            begin
                pedir(1'b0, mk(2, 2, 2, 2, 0), 8'd4);
                pedir(1'b0, mk(2, 2, 2, 2, 0), 8'd4);
            end
            begin
                pedir(1'b1, mk(3, -5, 0, 0, 0), 8'd2);
                pedir(1'b1, mk(3, -5, 0, 0, 0), 8'd2);
            end
        join
        drenar();

        check("gnt_queue_empty", gnt_q.size(), 0);
        check("done_queue_empty", done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
